// File: rtl/ddr2_pkg.sv
// Shared types for the DDR2 AXI controller front-end: queued request record and arbiter grant.
package ddr2_pkg;

    localparam int unsigned DDR2_ADDR_WIDTH = 28;
    localparam int unsigned DDR2_DATA_WIDTH = 32;
    localparam int unsigned DDR2_ID_WIDTH   = 4;
    localparam int unsigned DDR2_STRB_WIDTH = DDR2_DATA_WIDTH / 8;

    typedef struct packed {
        logic                       write;
        logic [DDR2_ID_WIDTH-1:0]   id;
        logic [DDR2_ADDR_WIDTH-1:0] addr;
        logic [DDR2_DATA_WIDTH-1:0] wdata;
        logic [DDR2_STRB_WIDTH-1:0] wstrb;
    } ddr2_req_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/ddr2_req_fifo.sv
// Synchronous request FIFO; head entry is read combinationally, occupancy exported as a count.
module ddr2_req_fifo
    import ddr2_pkg::*;
#(
    parameter type         entry_t = ddr2_req_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  entry_t                     data_i,
    input  logic                       pop_i,
    output entry_t                     data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(DEPTH)) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ddr2_axi_req_queue.sv
// AXI4-Lite AW/W/AR front-end: holds one beat per channel, pairs AW with W, round-robins
// writes against reads and queues the result for the controller FSM.
module ddr2_axi_req_queue
    import ddr2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DDR2_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DDR2_DATA_WIDTH,
    parameter int unsigned AXI_ID_WIDTH = DDR2_ID_WIDTH,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [AXI_ID_WIDTH-1:0]    S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    input  logic [AXI_ID_WIDTH-1:0]    S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic                       req_write,
    output logic [AXI_ID_WIDTH-1:0]    req_id,
    output logic [ADDR_WIDTH-1:0]      req_addr,
    output logic [DATA_WIDTH-1:0]      req_wdata,
    output logic [DATA_WIDTH/8-1:0]    req_wstrb,
    output logic [$clog2(DEPTH+1)-1:0] req_count
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    logic                    aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [AXI_ID_WIDTH-1:0] aw_id_q, ar_id_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [StrbW-1:0]        w_strb_q;
    arb_grant_t              last_grant_q, last_grant_d, grant;

    logic      aw_hs, w_hs, ar_hs, wr_cand, rd_cand, has_space, push, pop;
    ddr2_req_t push_req, head;

    assign S_AXI_AWREADY = !aw_full_q;
    assign S_AXI_WREADY  = !w_full_q;
    assign S_AXI_ARREADY = !ar_full_q;

    assign aw_hs = S_AXI_AWVALID && !aw_full_q;
    assign w_hs  = S_AXI_WVALID && !w_full_q;
    assign ar_hs = S_AXI_ARVALID && !ar_full_q;
    assign pop   = req_valid && req_ready;

    always_comb begin
        wr_cand   = aw_full_q && w_full_q;
        rd_cand   = ar_full_q;
        has_space = (req_count != CntW'(DEPTH)) || pop;

        if (wr_cand && rd_cand) begin
            grant = (last_grant_q == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
        end else if (rd_cand) begin
            grant = GRANT_READ;
        end else begin
            grant = GRANT_WRITE;
        end
        push = (wr_cand || rd_cand) && has_space;

        push_req       = '0;
        push_req.write = (grant == GRANT_WRITE);
        if (grant == GRANT_WRITE) begin
            push_req.id    = aw_id_q;
            push_req.addr  = aw_addr_q;
            push_req.wdata = w_data_q;
            push_req.wstrb = w_strb_q;
        end else begin
            push_req.id   = ar_id_q;
            push_req.addr = ar_addr_q;
        end

        last_grant_d = push ? grant : last_grant_q;

        // A slot cannot be refilled in its push cycle: its READY is still low.
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        if (push && (grant == GRANT_WRITE)) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (push && (grant == GRANT_READ)) begin
            ar_full_d = 1'b0;
        end
        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
        if (ar_hs) ar_full_d = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            ar_full_q    <= 1'b0;
            aw_id_q      <= '0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            last_grant_q <= GRANT_READ;
        end else begin
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            ar_full_q    <= ar_full_d;
            last_grant_q <= last_grant_d;
            if (aw_hs) begin
                aw_id_q   <= S_AXI_AWID;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (ar_hs) begin
                ar_id_q   <= S_AXI_ARID;
                ar_addr_q <= S_AXI_ARADDR;
            end
        end
    end

    ddr2_req_fifo #(
        .entry_t (ddr2_req_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (req_count)
    );

    assign req_valid = (req_count != '0);
    assign req_write = head.write;
    assign req_id    = head.id;
    assign req_addr  = head.addr;
    assign req_wdata = head.wdata;
    assign req_wstrb = head.wstrb;

endmodule

// File: tb/tb_ddr2_axi_req_queue.sv
// Bench for ddr2_axi_req_queue: cycle vectors, directed corner sequences and random traffic
// checked against a per-channel ordering scoreboard.
module tb_ddr2_axi_req_queue;
    import ddr2_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWID, S_AXI_ARID;
    logic [27:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_id;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_count;

    ddr2_axi_req_queue #(
        .ADDR_WIDTH   (28),
        .DATA_WIDTH   (32),
        .AXI_ID_WIDTH (4),
        .DEPTH        (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_id        (req_id),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_count     (req_count)
    );

    always #5 ACLK = ~ACLK;

    // {aw, w, ar, rr} inputs, {awready, wready, arready, valid, count, write} expected
    typedef struct packed {
        logic       aw, w, ar, rr;
        logic       e_awr, e_wr, e_arr, e_valid;
        logic [2:0] e_cnt;
        logic       e_write;
    } vec_t;

    vec_t      vecs [15];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_pops, aw_left, w_left, ar_left, prob, rr_mode, max_cnt;
    bit        drv_en, sb_en;
    ddr2_req_t aw_q[$], w_q[$], wr_exp[$], rd_exp[$];
    bit        order_q[$];

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit idle();
        return aw_left == 0 && w_left == 0 && ar_left == 0 && !S_AXI_AWVALID && !S_AXI_WVALID
            && !S_AXI_ARVALID && aw_q.size() == 0 && w_q.size() == 0 && wr_exp.size() == 0
            && rd_exp.size() == 0;
    endfunction

    task automatic clear_model();
        aw_q.delete(); w_q.delete(); wr_exp.delete(); rd_exp.delete(); order_q.delete();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        aw_left = 0; w_left = 0; ar_left = 0; n_pops = 0; max_cnt = 0;
    endtask

    task automatic do_reset();
        ARESET    = 1'b1;
        req_ready = 1'b0;
        rr_mode   = 0;
        clear_model();
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        chk("reset_state", 128'({req_valid, req_count, S_AXI_AWREADY, S_AXI_WREADY,
            S_AXI_ARREADY, req_write, req_id, req_addr, req_wdata, req_wstrb}),
            128'({1'b0, 3'd0, 3'b111, 1'b0, 4'h0, 28'h0, 32'h0, 4'h0}));
    endtask

    // One clock: sample handshakes at negedge, then drive next inputs 1 after the edge.
    task automatic cycle();
        logic      aw_hs, w_hs, ar_hs, pop;
        ddr2_req_t e, head;
        @(negedge ACLK);
        aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs  = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
        pop   = req_valid && req_ready;
        if (sb_en) begin
            if (aw_hs) begin
                e = '0; e.write = 1'b1; e.id = S_AXI_AWID; e.addr = S_AXI_AWADDR;
                aw_q.push_back(e);
            end
            if (w_hs) begin
                e = '0; e.wdata = S_AXI_WDATA; e.wstrb = S_AXI_WSTRB;
                w_q.push_back(e);
            end
            if (ar_hs) begin
                e = '0; e.id = S_AXI_ARID; e.addr = S_AXI_ARADDR;
                rd_exp.push_back(e);
            end
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                e = aw_q.pop_front();
                head = w_q.pop_front();
                e.wdata = head.wdata; e.wstrb = head.wstrb;
                wr_exp.push_back(e);
            end
            if (int'(req_count) > max_cnt) max_cnt = int'(req_count);
            if (pop) begin
                head = '0;
                head.write = req_write; head.id = req_id; head.addr = req_addr;
                head.wdata = req_wdata; head.wstrb = req_wstrb;
                n_pops++;
                order_q.push_back(req_write);
                if (req_write ? wr_exp.size() == 0 : rd_exp.size() == 0) begin
                    chk("pop_expected", 128'(head), 128'(0));
                end else begin
                    e = req_write ? wr_exp.pop_front() : rd_exp.pop_front();
                    chk("pop_entry", 128'(head), 128'(e));
                end
            end
        end
        @(posedge ACLK);
        #1;
        if (drv_en) begin
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            if (ar_hs) S_AXI_ARVALID = 1'b0;
            if (!S_AXI_AWVALID && aw_left > 0 && $urandom_range(99) < prob) begin
                S_AXI_AWVALID = 1'b1; S_AXI_AWID = 4'($urandom); S_AXI_AWADDR = 28'($urandom);
                aw_left--;
            end
            if (!S_AXI_WVALID && w_left > 0 && $urandom_range(99) < prob) begin
                S_AXI_WVALID = 1'b1; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'($urandom);
                w_left--;
            end
            if (!S_AXI_ARVALID && ar_left > 0 && $urandom_range(99) < prob) begin
                S_AXI_ARVALID = 1'b1; S_AXI_ARID = 4'($urandom); S_AXI_ARADDR = 28'($urandom);
                ar_left--;
            end
            req_ready = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(1) == 1);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (!idle() && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 128'(idle()), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ddr2_req_t exp_w, exp_r;
        vec_t      v;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0;
        drv_en = 1'b0; sb_en = 1'b0; prob = 100;

        vecs[0]  = 12'b1101_1110_000_0;
        vecs[1]  = 12'b0001_0010_000_0;
        vecs[2]  = 12'b0001_1111_001_1;
        vecs[3]  = 12'b0101_1110_000_0;
        vecs[4]  = 12'b0001_1010_000_0;
        vecs[5]  = 12'b0001_1010_000_0;
        vecs[6]  = 12'b1001_1010_000_0;
        vecs[7]  = 12'b0001_0010_000_0;
        vecs[8]  = 12'b0001_1111_001_1;
        vecs[9]  = 12'b1110_1110_000_0;
        vecs[10] = 12'b0000_0000_000_0;
        vecs[11] = 12'b0000_0011_001_0;
        vecs[12] = 12'b0001_1111_010_0;
        vecs[13] = 12'b0001_1111_001_1;
        vecs[14] = 12'b0001_1110_000_0;
        exp_w = '{write: 1'b1, id: 4'd3, addr: 28'h0000800, wdata: 32'hDEADBEEF, wstrb: 4'hF};
        exp_r = '{write: 1'b0, id: 4'd5, addr: 28'h0000123, wdata: 32'h0, wstrb: 4'h0};

        // Single write latency, early W beat, and write/read arbitration after a write.
        do_reset();
        S_AXI_AWID = exp_w.id; S_AXI_AWADDR = exp_w.addr;
        S_AXI_WDATA = exp_w.wdata; S_AXI_WSTRB = exp_w.wstrb;
        S_AXI_ARID = exp_r.id; S_AXI_ARADDR = exp_r.addr;
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            S_AXI_AWVALID = v.aw; S_AXI_WVALID = v.w; S_AXI_ARVALID = v.ar; req_ready = v.rr;
            @(negedge ACLK);
            chk($sformatf("vec%0d", i),
                128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, req_valid, req_count}),
                128'({v.e_awr, v.e_wr, v.e_arr, v.e_valid, v.e_cnt}));
            if (v.e_valid) begin
                chk($sformatf("vec%0d_head", i),
                    128'({req_write, req_id, req_addr, req_wdata, req_wstrb}),
                    128'(v.e_write ? exp_w : exp_r));
            end
            @(posedge ACLK);
            #1;
        end

        drv_en = 1'b1; sb_en = 1'b1;

        // Writes and reads offered together from reset alternate W,R,W,R.
        do_reset();
        rr_mode = 1; prob = 100; aw_left = 4; w_left = 4; ar_left = 4;
        drain(200, "alt_drain");
        chk("alt_len", 128'(order_q.size()), 128'(8));
        if (order_q.size() >= 4) begin
            chk("alt_order", 128'({order_q[0], order_q[1], order_q[2], order_q[3]}),
                128'(4'b1010));
        end else begin
            chk("alt_order", 128'(order_q.size()), 128'(4));
        end

        // Backpressure: FIFO saturates, then pop and push in the same cycle.
        do_reset();
        rr_mode = 0; prob = 100; aw_left = 6; w_left = 6;
        repeat (20) cycle();
        chk("full_count", 128'(req_count), 128'(4));
        chk("full_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b00));
        req_ready = 1'b1;
        cycle();
        chk("pop_push_count", 128'(req_count), 128'(4));
        chk("pop_push_pops", 128'(n_pops), 128'(1));
        rr_mode = 1; req_ready = 1'b1;
        drain(200, "full_drain");
        chk("full_total", 128'(n_pops), 128'(6));

        // Reset with 3 queued writes and one held W beat.
        do_reset();
        rr_mode = 0; prob = 100; aw_left = 3; w_left = 4;
        repeat (15) cycle();
        chk("pre_rst_count", 128'(req_count), 128'(3));
        chk("pre_rst_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b10));
        #1 ARESET = 1'b1;
        #1 chk("rst_async", 128'({req_valid, req_count, S_AXI_AWREADY, S_AXI_WREADY,
               S_AXI_ARREADY}), 128'({1'b0, 3'd0, 3'b111}));
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        clear_model();
        chk("rst_next", 128'({req_valid, req_count, S_AXI_AWREADY, S_AXI_WREADY,
            S_AXI_ARREADY}), 128'({1'b0, 3'd0, 3'b111}));
        rr_mode = 1; req_ready = 1'b1;
        repeat (6) cycle();
        chk("no_stale", 128'(n_pops), 128'(0));
        aw_left = 1; w_left = 1;
        drain(50, "post_rst_drain");
        chk("post_rst_total", 128'(n_pops), 128'(1));

        // Random traffic with random backpressure.
        do_reset();
        rr_mode = 2; prob = 40; aw_left = 80; w_left = 80; ar_left = 80;
        drain(5000, "rand_drain");
        chk("rand_total", 128'(n_pops), 128'(160));
        chk("rand_count_bound", 128'(max_cnt <= 4), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
